// File: rtl/pipe_pkg.sv
// Shared pipeline control definitions: register index width, forward-mux codes, hazard FSM states.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package pipe_pkg;

    localparam int REG_ADDR_W = 5;

    // Forward-mux select codes, shared with the ALU operand muxes; 2'b11 is never produced
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b01;
    localparam logic [1:0] FWD_MEMWB   = 2'b10;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } hz_state_t;

endpackage

// File: rtl/fwd_select_unit.sv
// Per-operand forward select: compares one Execute source tag against EX/MEM and MEM/WB destinations.
// Latency: purely combinational, same cycle.
// Backpressure: none; the caller decides when the tag is valid.
module fwd_select_unit #(
    parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] exRs,
    input  logic                  exRsValid,
    input  logic [REG_ADDR_W-1:0] memRd,
    input  logic                  memRegWrite,
    input  logic [REG_ADDR_W-1:0] wbRd,
    input  logic                  wbRegWrite,
    output logic [1:0]            forwardSelect
);
    import pipe_pkg::*;

    // Youngest producer wins: EX/MEM before MEM/WB; x0 is hardwired zero and never forwards
    always_comb begin
        forwardSelect = FWD_REGFILE;
        if (exRsValid && (exRs != '0)) begin
            if (memRegWrite && (memRd == exRs)) begin
                forwardSelect = FWD_EXMEM;
            end else if (wbRegWrite && (wbRd == exRs)) begin
                forwardSelect = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller beside Execute: operand forward selects, load-use bubbles, MUL/DIV stalls, branch flush.
// Latency: selects and stall/flush outputs are combinational in the same cycle; shadow tags, FSM and counters update next edge.
// Backpressure: stalls hold IF/ID/EX registers; MUL/DIV stall is bounded by a watchdog that releases it and sets a sticky flag.
module hazard_forward_ctrl #(
    parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W,
    parameter int CNT_W      = 32,
    parameter int MD_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [REG_ADDR_W-1:0] idRs1,
    input  logic [REG_ADDR_W-1:0] idRs2,
    input  logic                  idUsesRs1,
    input  logic                  idUsesRs2,
    input  logic [REG_ADDR_W-1:0] exRd,
    input  logic                  exMemRead,
    input  logic [REG_ADDR_W-1:0] memRd,
    input  logic                  memRegWrite,
    input  logic [REG_ADDR_W-1:0] wbRd,
    input  logic                  wbRegWrite,
    input  logic                  exMulDivStart,
    input  logic                  mulDivDone,
    input  logic                  branchTaken,
    output logic [1:0]            forwardSelect1,
    output logic [1:0]            forwardSelect2,
    output logic                  stallFetch,
    output logic                  stallDecode,
    output logic                  stallExecute,
    output logic                  flushFetch,
    output logic                  bubbleExecute,
    output logic                  mdTimeout,
    output logic [CNT_W-1:0]      stallCycleCount
);
    import pipe_pkg::*;

    localparam int TMR_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MD_TIMEOUT - 1);

    hz_state_t             state;
    hz_state_t             stateNext;
    logic [TMR_W-1:0]      mdTimer;
    logic [TMR_W-1:0]      mdTimerNext;
    logic                  mdTimeoutSet;
    logic [REG_ADDR_W-1:0] exRs1;
    logic [REG_ADDR_W-1:0] exRs2;
    logic                  exRs1Valid;
    logic                  exRs2Valid;
    logic                  loadUse;
    logic                  stallFetchInt;
    logic                  stallDecodeInt;
    logic                  stallExecuteInt;
    logic                  flushFetchInt;
    logic                  bubbleExecuteInt;

    fwd_select_unit #(.REG_ADDR_W(REG_ADDR_W)) uFwd1 (
        .exRs          (exRs1),
        .exRsValid     (exRs1Valid),
        .memRd         (memRd),
        .memRegWrite   (memRegWrite),
        .wbRd          (wbRd),
        .wbRegWrite    (wbRegWrite),
        .forwardSelect (forwardSelect1)
    );

    fwd_select_unit #(.REG_ADDR_W(REG_ADDR_W)) uFwd2 (
        .exRs          (exRs2),
        .exRsValid     (exRs2Valid),
        .memRd         (memRd),
        .memRegWrite   (memRegWrite),
        .wbRd          (wbRd),
        .wbRegWrite    (wbRegWrite),
        .forwardSelect (forwardSelect2)
    );

    assign loadUse = exMemRead && (exRd != '0) &&
                     ((idUsesRs1 && (idRs1 == exRd)) || (idUsesRs2 && (idRs2 == exRd)));

    // Mealy control: branch flush beats MUL/DIV start beats load-use; MD_BUSY ignores branch and load-use
    always_comb begin
        stallFetchInt    = 1'b0;
        stallDecodeInt   = 1'b0;
        stallExecuteInt  = 1'b0;
        flushFetchInt    = 1'b0;
        bubbleExecuteInt = 1'b0;
        stateNext        = state;
        mdTimerNext      = '0;
        mdTimeoutSet     = 1'b0;
        case (state)
            RUN: begin
                if (branchTaken) begin
                    flushFetchInt    = 1'b1;
                    bubbleExecuteInt = 1'b1;
                end else if (exMulDivStart) begin
                    stallFetchInt   = 1'b1;
                    stallDecodeInt  = 1'b1;
                    stallExecuteInt = 1'b1;
                    if (!mulDivDone) begin
                        stateNext = MD_BUSY;
                    end
                end else if (loadUse) begin
                    stallFetchInt    = 1'b1;
                    stallDecodeInt   = 1'b1;
                    bubbleExecuteInt = 1'b1;
                end
            end
            MD_BUSY: begin
                if (mulDivDone) begin
                    stateNext = RUN;
                end else if (mdTimer == TMR_LAST) begin
                    mdTimeoutSet = 1'b1;
                    stateNext    = RUN;
                end else begin
                    stallFetchInt   = 1'b1;
                    stallDecodeInt  = 1'b1;
                    stallExecuteInt = 1'b1;
                    mdTimerNext     = mdTimer + TMR_W'(1);
                end
            end
            default: stateNext = RUN;
        endcase
    end

    // Control outputs are forced low while reset is asserted, whatever the inputs say
    always_comb begin
        stallFetch    = resetN & stallFetchInt;
        stallDecode   = resetN & stallDecodeInt;
        stallExecute  = resetN & stallExecuteInt;
        flushFetch    = resetN & flushFetchInt;
        bubbleExecute = resetN & bubbleExecuteInt;
    end

    // FSM state, MUL/DIV watchdog timer and sticky timeout flag
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= RUN;
            mdTimer   <= '0;
            mdTimeout <= 1'b0;
        end else begin
            state   <= stateNext;
            mdTimer <= mdTimerNext;
            if (mdTimeoutSet) begin
                mdTimeout <= 1'b1;
            end
        end
    end

    // ID/EX tag shadow: hold on Execute stall, clear on bubble, hold on Decode-only stall, else capture
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            exRs1      <= '0;
            exRs2      <= '0;
            exRs1Valid <= 1'b0;
            exRs2Valid <= 1'b0;
        end else if (stallExecuteInt) begin
            exRs1 <= exRs1;
        end else if (bubbleExecuteInt) begin
            exRs1      <= '0;
            exRs2      <= '0;
            exRs1Valid <= 1'b0;
            exRs2Valid <= 1'b0;
        end else if (!stallDecodeInt) begin
            exRs1      <= idRs1;
            exRs2      <= idRs2;
            exRs1Valid <= idUsesRs1;
            exRs2Valid <= idUsesRs2;
        end
    end

    // Saturating count of cycles with the fetch stage held
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            stallCycleCount <= '0;
        end else if (stallFetchInt && (stallCycleCount != '1)) begin
            stallCycleCount <= stallCycleCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: forwarding priority, load-use, MUL/DIV stall and watchdog, branch flush, reset.
// Latency: checks combinational outputs mid-cycle and registered state one cycle after each edge.
// Backpressure: mulDivDone is driven directly; every wait is a fixed cycle count.
module tb_hazard_forward_ctrl;

    logic        clk;
    logic        resetN;
    logic [4:0]  idRs1, idRs2, exRd, memRd, wbRd;
    logic        idUsesRs1, idUsesRs2, exMemRead, memRegWrite, wbRegWrite;
    logic        exMulDivStart, mulDivDone, branchTaken;
    logic [1:0]  forwardSelect1, forwardSelect2;
    logic        stallFetch, stallDecode, stallExecute, flushFetch, bubbleExecute, mdTimeout;
    logic [31:0] stallCycleCount;

    int checks = 0;
    int errors = 0;

    hazard_forward_ctrl dut (
        .clk             (clk),
        .resetN          (resetN),
        .idRs1           (idRs1),
        .idRs2           (idRs2),
        .idUsesRs1       (idUsesRs1),
        .idUsesRs2       (idUsesRs2),
        .exRd            (exRd),
        .exMemRead       (exMemRead),
        .memRd           (memRd),
        .memRegWrite     (memRegWrite),
        .wbRd            (wbRd),
        .wbRegWrite      (wbRegWrite),
        .exMulDivStart   (exMulDivStart),
        .mulDivDone      (mulDivDone),
        .branchTaken     (branchTaken),
        .forwardSelect1  (forwardSelect1),
        .forwardSelect2  (forwardSelect2),
        .stallFetch      (stallFetch),
        .stallDecode     (stallDecode),
        .stallExecute    (stallExecute),
        .flushFetch      (flushFetch),
        .bubbleExecute   (bubbleExecute),
        .mdTimeout       (mdTimeout),
        .stallCycleCount (stallCycleCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        idRs1 = '0; idRs2 = '0; idUsesRs1 = 1'b0; idUsesRs2 = 1'b0;
        exRd = '0; exMemRead = 1'b0;
        memRd = '0; memRegWrite = 1'b0; wbRd = '0; wbRegWrite = 1'b0;
        exMulDivStart = 1'b0; mulDivDone = 1'b0; branchTaken = 1'b0;
    endtask

    initial begin
        clr();
        resetN = 1'b0;

        // Reset: outputs low even with active stimulus
        exMulDivStart = 1'b1;
        exMemRead = 1'b1; exRd = 5'd7; idRs1 = 5'd7; idUsesRs1 = 1'b1;
        #12;
        chk("rst_stallFetch", 32'(stallFetch), 32'd0);
        chk("rst_stallExecute", 32'(stallExecute), 32'd0);
        chk("rst_bubble", 32'(bubbleExecute), 32'd0);
        exMulDivStart = 1'b0; branchTaken = 1'b1;
        #1;
        chk("rst_flushFetch", 32'(flushFetch), 32'd0);
        chk("rst_fwd1", 32'(forwardSelect1), 32'd0);
        chk("rst_mdTimeout", 32'(mdTimeout), 32'd0);
        chk("rst_count", stallCycleCount, 32'd0);
        clr();
        tick();
        resetN = 1'b1;

        // Test 1/2: shadow rs1=5 valid, rs2=0 valid
        idRs1 = 5'd5; idUsesRs1 = 1'b1; idRs2 = 5'd0; idUsesRs2 = 1'b1;
        #1;
        chk("idle_stallFetch", 32'(stallFetch), 32'd0);
        tick();
        clr();
        memRd = 5'd5; memRegWrite = 1'b1; wbRd = 5'd5; wbRegWrite = 1'b1;
        #1;
        chk("fwd1_exmem_priority", 32'(forwardSelect1), 32'd1);
        memRd = 5'd0;
        #1;
        chk("fwd2_x0_never", 32'(forwardSelect2), 32'd0);
        chk("fwd1_memwb", 32'(forwardSelect1), 32'd2);
        wbRegWrite = 1'b0;
        #1;
        chk("fwd1_regfile", 32'(forwardSelect1), 32'd0);
        tick();

        // Test 3: load-use on rs1=7
        clr();
        exMemRead = 1'b1; exRd = 5'd7; idRs1 = 5'd7; idUsesRs1 = 1'b0;
        #1;
        chk("lu_unused_no_stall", 32'(stallFetch), 32'd0);
        idUsesRs1 = 1'b1;
        #1;
        chk("lu_stallFetch", 32'(stallFetch), 32'd1);
        chk("lu_stallDecode", 32'(stallDecode), 32'd1);
        chk("lu_bubble", 32'(bubbleExecute), 32'd1);
        chk("lu_stallExecute", 32'(stallExecute), 32'd0);
        tick();
        exMemRead = 1'b0; wbRd = 5'd7; wbRegWrite = 1'b1;
        #1;
        chk("lu_release", 32'(stallFetch), 32'd0);
        chk("lu_bubble_no_fwd", 32'(forwardSelect1), 32'd0);
        chk("lu_count", stallCycleCount, 32'd1);
        tick();
        #1;
        chk("lu_fwd_memwb", 32'(forwardSelect1), 32'd2);
        clr();
        tick();

        // Test 4: MUL/DIV done after 4 cycles
        exMulDivStart = 1'b1;
        #1;
        chk("md_start_stallExecute", 32'(stallExecute), 32'd1);
        chk("md_start_stallDecode", 32'(stallDecode), 32'd1);
        tick();
        exMulDivStart = 1'b0;
        for (int i = 1; i < 4; i++) begin
            branchTaken = (i == 2);
            #1;
            chk("md_busy_stallFetch", 32'(stallFetch), 32'd1);
            if (i == 2) chk("md_busy_branch_ignored", 32'(flushFetch), 32'd0);
            tick();
        end
        branchTaken = 1'b0; mulDivDone = 1'b1;
        #1;
        chk("md_done_stallFetch", 32'(stallFetch), 32'd0);
        chk("md_done_stallExecute", 32'(stallExecute), 32'd0);
        tick();
        mulDivDone = 1'b0;
        #1;
        chk("md_count", stallCycleCount, 32'd5);
        chk("md_back_run", 32'(stallFetch), 32'd0);
        // Start and done in the same cycle: one stall cycle, no MD_BUSY
        exMulDivStart = 1'b1; mulDivDone = 1'b1;
        #1;
        chk("md_instant_stall", 32'(stallExecute), 32'd1);
        tick();
        clr();
        #1;
        chk("md_instant_run", 32'(stallFetch), 32'd0);
        chk("md_instant_count", stallCycleCount, 32'd6);

        // Test 5: branch beats load-use
        branchTaken = 1'b1; exMemRead = 1'b1; exRd = 5'd3; idRs2 = 5'd3; idUsesRs2 = 1'b1;
        #1;
        chk("br_flushFetch", 32'(flushFetch), 32'd1);
        chk("br_bubble", 32'(bubbleExecute), 32'd1);
        chk("br_stallFetch", 32'(stallFetch), 32'd0);
        chk("br_stallDecode", 32'(stallDecode), 32'd0);
        tick();
        clr();
        #1;
        chk("br_count", stallCycleCount, 32'd6);

        // Test 6: MUL/DIV watchdog
        exMulDivStart = 1'b1;
        tick();
        clr();
        for (int i = 0; i < 64; i++) begin
            #1;
            chk("wd_stall", 32'(stallFetch), (i < 63) ? 32'd1 : 32'd0);
            if (i == 63) chk("wd_flag_before", 32'(mdTimeout), 32'd0);
            tick();
        end
        #1;
        chk("wd_flag_set", 32'(mdTimeout), 32'd1);
        chk("wd_released", 32'(stallFetch), 32'd0);
        chk("wd_count", stallCycleCount, 32'd70);
        tick();
        #1;
        chk("wd_flag_sticky", 32'(mdTimeout), 32'd1);

        // Reset in the middle of MD_BUSY
        exMulDivStart = 1'b1;
        tick();
        clr();
        tick();
        #1;
        chk("rst2_busy_before", 32'(stallExecute), 32'd1);
        resetN = 1'b0;
        #1;
        chk("rst2_stallFetch", 32'(stallFetch), 32'd0);
        chk("rst2_stallExecute", 32'(stallExecute), 32'd0);
        chk("rst2_mdTimeout", 32'(mdTimeout), 32'd0);
        chk("rst2_count", stallCycleCount, 32'd0);
        tick();
        resetN = 1'b1;
        #1;
        chk("rst2_run_no_stall", 32'(stallFetch), 32'd0);
        branchTaken = 1'b1;
        #1;
        chk("rst2_run_flush", 32'(flushFetch), 32'd1);
        clr();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
